// File: rtl/adc_serial_capture.sv
// Serial-ADC front end: timer-paced chip-select frames, N_CHANNELS adc_sd lanes shifted in parallel,
// one word per lane on a valid/ready port. Define ADC_SIGNED_EN to emit two's-complement words.
module adc_serial_capture #(
  parameter int N_CHANNELS    = 1,
  parameter int DATA_BITS     = 12,
  parameter int LEAD_BITS     = 4,
  parameter int TRAIL_BITS    = 0,
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_CYCLES = 1000,
  parameter int CS_QUIET      = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            run,
  output logic                            adc_cs,
  output logic                            adc_clk,
  input  logic [N_CHANNELS-1:0]           adc_sd,
  output logic [N_CHANNELS*DATA_BITS-1:0] sample_data,
  output logic                            sample_valid,
  input  logic                            sample_ready,
  output logic                            overrun
);

  localparam int FRAME_BITS = LEAD_BITS + DATA_BITS + TRAIL_BITS;
  localparam int TIMER_W    = $clog2(SAMPLE_CYCLES + 1);
  localparam int DIV_W      = $clog2(CLK_DIV + 1);
  localparam int BIT_W      = $clog2(FRAME_BITS + 1);
  localparam int QUIET_W    = $clog2(CS_QUIET + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_DONE,
    S_QUIET
  } state_e;

  state_e                          state_q;
  logic [TIMER_W-1:0]              timer_q;
  logic [TIMER_W-1:0]              timer_d;
  logic                            trigger;
  logic [DIV_W-1:0]                div_q;
  logic [BIT_W-1:0]                bit_q;
  logic [QUIET_W-1:0]              quiet_q;
  logic                            adc_cs_q;
  logic                            adc_clk_q;
  logic                            valid_q;
  logic                            overrun_q;
  logic [N_CHANNELS*DATA_BITS-1:0] data_q;
  logic [N_CHANNELS*DATA_BITS-1:0] data_d;
  logic [DATA_BITS-1:0]            shift_q [N_CHANNELS];
  logic                            div_end;
  logic                            data_bit;
  logic                            shift_en;

  // NOTE: combinational blocks assign every output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    trigger = run && (timer_q == TIMER_W'(SAMPLE_CYCLES - 1));
    timer_d = timer_q + TIMER_W'(1);
    if (!run || trigger) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  always_comb begin
    div_end  = (div_q == DIV_W'(CLK_DIV - 1));
    data_bit = (bit_q >= BIT_W'(LEAD_BITS)) && (bit_q < BIT_W'(LEAD_BITS + DATA_BITS));
    shift_en = (state_q == S_SHIFT) && div_end && !adc_clk_q && data_bit;
  end

  // Lane c only ever touches its own slice; the MSB flip turns offset binary into two's complement.
  always_comb begin
    data_d = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
`ifdef ADC_SIGNED_EN
      data_d[c*DATA_BITS +: DATA_BITS] = shift_q[c] ^ {1'b1, {(DATA_BITS-1){1'b0}}};
`else
      data_d[c*DATA_BITS +: DATA_BITS] = shift_q[c];
`endif
    end
  end

  // NOTE: the shift registers carry no reset: every data bit is overwritten before each load.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        shift_q[c] <= {shift_q[c][DATA_BITS-2:0], adc_sd[c]};
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      adc_cs_q  <= 1'b1;
      adc_clk_q <= 1'b1;
      div_q     <= '0;
      bit_q     <= '0;
      quiet_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (valid_q && sample_ready) begin
        valid_q <= 1'b0;
      end
      if (trigger && (state_q != S_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (trigger) begin
            state_q  <= S_SETUP;
            adc_cs_q <= 1'b0;
            div_q    <= '0;
            bit_q    <= '0;
          end
        end
        S_SETUP: begin
          if (div_end) begin
            div_q     <= '0;
            adc_clk_q <= 1'b0;
            state_q   <= S_SHIFT;
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_SHIFT: begin
          if (div_end) begin
            div_q <= '0;
            if (!adc_clk_q) begin
              adc_clk_q <= 1'b1;
            end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
              // Load wins over the clear above, so a same-edge consume keeps valid high.
              state_q  <= S_DONE;
              adc_cs_q <= 1'b1;
              data_q   <= data_d;
              valid_q  <= 1'b1;
              if (valid_q && !sample_ready) begin
                overrun_q <= 1'b1;
              end
            end else begin
              bit_q     <= bit_q + BIT_W'(1);
              adc_clk_q <= 1'b0;
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_QUIET;
          quiet_q <= '0;
        end
        S_QUIET: begin
          if (quiet_q == QUIET_W'(CS_QUIET - 1)) begin
            state_q <= S_IDLE;
          end else begin
            quiet_q <= quiet_q + QUIET_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign adc_cs       = adc_cs_q;
  assign adc_clk      = adc_clk_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule
